// File: rtl/ram2_arb_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
package ram2_arb_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick.
//   req       : raw requests, bit i = requester i
//   mask      : requests to ignore this cycle
//   prio      : index that wins when both remaining requests are present
//   gnt_valid : at least one eligible request
//   gnt_idx   : index of the granted requester (0 when gnt_valid is low)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       prio,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] elig;

  always_comb begin
    elig      = req & ~mask;
    gnt_valid = |elig;
    gnt_idx   = 1'b0;
    case (elig)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = prio;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram2_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port RAM between two
// requesters. Each access takes one ACCESS cycle followed by one DONE cycle
// in which the winner's ack is high.
//   clk, rst                  : clock, asynchronous active-high reset
//   reqN/weN/addrN/wdataN     : requester N request, direction, address, write data
//   ackN                      : one-cycle completion pulse for requester N
//   rdataN                    : last read result for requester N
//   busy                      : high while in ACCESS or DONE
//   ram_ena/ram_wena/ram_addr : RAM control
//   ram_data                  : bidirectional RAM data bus (driven only on write ACCESS)
module ram2_arbiter
  import ram2_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          ram_ena,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data
);

  state_t        state;
  logic          winner;
  logic          prio;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;

  logic [1:0]    mask;
  logic          gnt_valid;
  logic          gnt_idx;
  logic          data_drive;

  // In DONE the requester just served still has req high; hide it so the
  // other side can go straight to ACCESS.
  assign mask = (state == DONE) ? (winner ? 2'b10 : 2'b01) : 2'b00;

  rr_arb2 u_pick (
    .req       ({req1, req0}),
    .mask      (mask),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // RAM side decoded purely from registers so nothing glitches on the port.
  assign ram_ena    = (state == ACCESS);
  assign ram_wena   = ram_ena & we_r;
  assign ram_addr   = addr_r;
  assign data_drive = ram_ena & we_r;
  assign ram_data   = data_drive ? wdata_r : 'z;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      winner  <= 1'b0;
      prio    <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (gnt_valid) begin
            winner  <= gnt_idx;
            we_r    <= gnt_idx ? we1 : we0;
            addr_r  <= gnt_idx ? addr1 : addr0;
            wdata_r <= gnt_idx ? wdata1 : wdata0;
            state   <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (!we_r) begin
            if (winner) rdata1 <= ram_data;
            else        rdata0 <= ram_data;
          end
          if (winner) ack1 <= 1'b1;
          else        ack0 <= 1'b1;
          prio  <= ~winner;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram2_arbiter.md
Name: ram2_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the single-port 32x32 RAM (ram2). It shares the RAM's one ena/wena/addr/bidirectional-data port between two requesters. Each requester gets a simple req/ack handshake with separate write and read data. The block owns the RAM-side tristate data bus, and is the only master of that port.

Parameters:
AW, 5, address width; matches RAM depth 2**AW = 32.
DW, 32, data width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 access request; held high until ack0.
we0  input  1  requester 0: 1 = write, 0 = read; stable while req0 high.
addr0  input  AW  requester 0 address; stable while req0 high.
wdata0  input  DW  requester 0 write data; stable while req0 high.
ack0  output  1  one-cycle pulse: requester 0 access complete.
rdata0  output  DW  requester 0 read result; valid from the ack0 cycle until its next read completes.
req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1.
busy  output  1  high in ACCESS and DONE.
ram_ena  output  1  to RAM ena.
ram_wena  output  1  to RAM wena.
ram_addr  output  AW  to RAM addr.
ram_data  inout  DW  RAM data bus. Driven by the arbiter only during a write ACCESS; high-Z otherwise.

Behaviour:
- States: IDLE, ACCESS, DONE. Registers: state, winner (1 bit), prio (1 bit), we_r, addr_r, wdata_r, rdata0, rdata1, ack0, ack1.
- Reset (async, immediate):
  - state = IDLE, prio = 0, winner = 0.
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0; we_r = 0, addr_r = 0, wdata_r = 0.
  - ram_ena = 0, ram_wena = 0, ram_addr = 0, ram_data = Z.
  - An access in progress is abandoned: no RAM write occurs and no ack is issued.
- Pick rule (evaluated in IDLE, and in DONE with the current winner's req masked):
  - Only one eligible req: grant it.
  - Both eligible: grant requester prio.
  - On grant: winner <= granted index; capture its we/addr/wdata into we_r/addr_r/wdata_r; next state ACCESS.
  - No eligible req: next state IDLE.
- ACCESS (exactly one cycle):
  - ram_ena = 1, ram_wena = we_r, ram_addr = addr_r, all decoded from registered state (glitch-free).
  - If we_r = 1: ram_data = wdata_r, and the RAM writes on the closing edge.
  - If we_r = 0: ram_data = Z; on the closing edge, ram_data is captured into rdata of the winner.
  - On the closing edge: ack(winner) <= 1, prio <= ~winner, next state DONE.
- DONE (one cycle):
  - ack(winner) = 1; ram_ena = 0; ram_data = Z.
  - The pick rule is applied with req(winner) masked.
  - A pending req from the other requester goes directly to ACCESS; otherwise go to IDLE.
  - ack clears on exit from DONE.
- Requester contract: deassert req on the edge that ends the ack cycle. A req still high in the following IDLE is treated as a new request.
- Latency: req high before edge E0 (in IDLE) → ACCESS in cycle E0–E1 → ack in cycle E1–E2.
- Throughput:
  - One access per 2 cycles when both requesters keep requesting (strict alternation).
  - One access per 3 cycles for a single back-to-back requester.
- Bus contention rule: the arbiter drives ram_data only when state = ACCESS and we_r = 1. The RAM drives only when ram_ena = 1 and ram_wena = 0. These are mutually exclusive by construction; no turnaround cycle is needed.
- rdata of the non-winner, and rdata of a write winner, hold their values.
- Address wrap: none. addr_r is passed through unchanged; all 2**AW addresses are legal.

Decomposition:
- Package ram2_arb_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - localparams AW_DEF = 5, DW_DEF = 32.
- Sub-module rr_arb2 (combinational 2-way round-robin pick: inputs req[1:0], mask[1:0], prio; outputs gnt_valid, gnt_idx). Instantiated once.
- Everything else stays in ram2_arbiter.

Test Plan:
- Reset mid-write: assert rst during an ACCESS write of 0xDEADBEEF to addr 3 → ram_ena drops to 0 at once, ram_data goes Z, no ack; a later read of addr 3 returns the old value.
- Single write/read: req0 write 0x12345678 @ addr 5, then req0 read @ 5 → ack0 one cycle after ACCESS each time; rdata0 = 0x12345678; rdata1 unchanged (0).
- Simultaneous requests after reset: req0 write 0xA @ 1 and req1 write 0xB @ 2 in the same cycle → requester 0 served first (prio = 0), requester 1 in the very next ACCESS (DONE→ACCESS path); a 2-cycle spacing between ack0 and ack1.
- Fairness: both requesters continuously read (addr0 = 1, addr1 = 2) for 10 accesses → acks alternate 0,1,0,1…; rdata0 = 0xA and rdata1 = 0xB each time.
- Address extremes: write 0xFFFFFFFF @ 31 and 0x0 @ 0, then read both back → exact values returned; no aliasing between the two.
- Bus check: assertion that ram_data is never driven by both sides — arbiter drive and (ram_ena && !ram_wena) are never true together — across all of the above.
